// File: rtl/dino_pkg.sv
// Shared constants and types for the dino score display.
// Score width, digit count, converter states and 7-segment table.
package dino_pkg;

    localparam int SCORE_W    = 16;
    localparam int NUM_DIGITS = 5;
    localparam int BCD_W      = 4 * NUM_DIGITS;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_LATCH
    } conv_st_e;

    // {g,f,e,d,c,b,a}, active-high; index = nibble, A-F dark
    localparam logic [15:0][6:0] SEG7 = {
        7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
        7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: 16-bit binary to 5-digit BCD, 18 cycles.
// Ports: clk, rst_n, start, bin in; bcd (valid while done), done out.
module bin2bcd_seq
    import dino_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [SCORE_W-1:0] bin,
    output logic [BCD_W-1:0]   bcd,
    output logic               done
);

    conv_st_e           state_q, state_d;
    logic [SCORE_W-1:0] bin_q, bin_d;
    logic [BCD_W-1:0]   acc_q, acc_d;
    logic [3:0]         cnt_q, cnt_d;
    logic [BCD_W-1:0]   adj;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        adj     = acc_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (acc_q[4*i +: 4] >= 4'd5)
                        adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
                end
                {acc_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 4'd1;
                if (cnt_q == 4'd15)
                    state_d = ST_LATCH;
            end
            ST_LATCH: state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            bin_q   <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bcd  = acc_q;
    assign done = (state_q == ST_LATCH);

endmodule

// File: rtl/dino_score_display.sv
// Score display: high-score tracking, BCD conversion, 7-seg scan.
// Ports: clk, rst_n, score, game_over, show_high in; seg, digit_sel, conv_done, high_score out.
module dino_score_display
    import dino_pkg::*;
#(
    parameter int SCAN_DIV = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [SCORE_W-1:0]    score,
    input  logic                  game_over,
    input  logic                  show_high,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  conv_done,
    output logic [SCORE_W-1:0]    high_score
);

    localparam int              PRE_W   = $clog2(SCAN_DIV);
    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(SCAN_DIV - 1);

    logic [SCORE_W-1:0]    high_q, high_d;
    logic [BCD_W-1:0]      disp_q, disp_d;
    logic                  done_q, done_d;
    logic [PRE_W-1:0]      pre_q, pre_d;
    logic [2:0]            idx_q, idx_d;
    logic [NUM_DIGITS-1:0] sel_q, sel_d;
    logic [6:0]            seg_q, seg_d;

    logic [SCORE_W-1:0] src;
    logic [BCD_W-1:0]   bcd;
    logic               cv_done;
    logic [BCD_W-1:0]   upper;

    assign src = show_high ? high_q : score;

    bin2bcd_seq u_conv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (1'b1),
        .bin   (src),
        .bcd   (bcd),
        .done  (cv_done)
    );

    always_comb begin
        high_d = high_q;
        if (game_over && (score > high_q))
            high_d = score;

        disp_d = cv_done ? bcd : disp_q;
        done_d = cv_done;

        pre_d = pre_q + PRE_W'(1);
        idx_d = idx_q;
        if (pre_q == PRE_MAX) begin
            pre_d = '0;
            idx_d = (idx_q == 3'd4) ? 3'd0 : idx_q + 3'd1;
        end

        // select and segments both follow the next index so they move together
        sel_d = NUM_DIGITS'(1) << idx_d;
        upper = disp_q >> (4 * idx_d);
        if ((idx_d != 3'd0) && (upper == '0))
            seg_d = '0;
        else
            seg_d = SEG7[upper[3:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            high_q <= '0;
            disp_q <= '0;
            done_q <= 1'b0;
            pre_q  <= '0;
            idx_q  <= '0;
            sel_q  <= '0;
            seg_q  <= '0;
        end else begin
            high_q <= high_d;
            disp_q <= disp_d;
            done_q <= done_d;
            pre_q  <= pre_d;
            idx_q  <= idx_d;
            sel_q  <= sel_d;
            seg_q  <= seg_d;
        end
    end

    assign seg        = seg_q;
    assign digit_sel  = sel_q;
    assign conv_done  = done_q;
    assign high_score = high_q;

endmodule

// File: tb/tb_dino_score_display.sv
// Directed bench for dino_score_display with SCAN_DIV=4.
// Covers reset, BCD digits, blanking, high score, hold and async reset.
module tb_dino_score_display;

    logic        clk;
    logic        rst_n;
    logic [15:0] score;
    logic        game_over;
    logic        show_high;
    logic [6:0]  seg;
    logic [4:0]  digit_sel;
    logic        conv_done;
    logic [15:0] high_score;

    int errs;
    int checks;

    dino_score_display #(.SCAN_DIV(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .score      (score),
        .game_over  (game_over),
        .show_high  (show_high),
        .seg        (seg),
        .digit_sel  (digit_sel),
        .conv_done  (conv_done),
        .high_score (high_score)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input string tag);
        bit hit;
        hit = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (conv_done) begin
                hit = 1;
                break;
            end
        end
        if (!hit)
            chk({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    // counts negedges from reset release up to the first conv_done
    task automatic first_done(input string tag);
        int n;
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1)
                chk({tag, "_sel0"}, 32'(digit_sel), 32'h01);
            if (conv_done) begin
                n = k;
                break;
            end
        end
        chk({tag, "_first_done"}, 32'(n), 32'd18);
    endtask

    task automatic check_display(input string tag,
                                 input logic [6:0] e0, input logic [6:0] e1,
                                 input logic [6:0] e2, input logic [6:0] e3,
                                 input logic [6:0] e4);
        logic [6:0] e [5];
        bit hit;
        e = '{e0, e1, e2, e3, e4};
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            hit = 0;
            for (int k = 0; k < 40; k++) begin
                if (digit_sel == 5'(1 << i)) begin
                    hit = 1;
                    break;
                end
                @(negedge clk);
            end
            if (!hit)
                chk($sformatf("%s_sel%0d", tag, i), 32'(digit_sel),
                    32'(1 << i));
            else
                chk($sformatf("%s_d%0d", tag, i), 32'(seg), 32'(e[i]));
        end
    endtask

    task automatic check_period(input string tag);
        int n;
        wait_done({tag, "_sync"});
        n = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1)
                chk({tag, "_width"}, 32'(conv_done), 32'd0);
            if (conv_done) begin
                n = k;
                break;
            end
        end
        chk({tag, "_period"}, 32'(n), 32'd18);
    endtask

    task automatic pulse_go(input logic [15:0] s);
        score     = s;
        game_over = 1'b1;
        @(negedge clk);
        game_over = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got 0 expected 1");
        $fatal(1, "timeout");
    end

    initial begin
        bit seen;
        logic [6:0] got;
        errs      = 0;
        checks    = 0;
        rst_n     = 1'b0;
        score     = '0;
        game_over = 1'b0;
        show_high = 1'b0;

        // 1: reset state and first conversion of 0
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'd0);
        chk("rst_sel", 32'(digit_sel), 32'd0);
        chk("rst_done", 32'(conv_done), 32'd0);
        chk("rst_high", 32'(high_score), 32'd0);
        rst_n = 1'b1;
        first_done("t1");
        check_display("t1", 7'h3F, 7'h00, 7'h00, 7'h00, 7'h00);

        // 2: 12345 and pulse timing
        score = 16'd12345;
        wait_done("t2a");
        wait_done("t2b");
        check_display("t2", 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06);
        check_period("t2");

        // 3: maximum and interior zero
        score = 16'd65535;
        wait_done("t3a");
        wait_done("t3b");
        check_display("t3max", 7'h6D, 7'h4F, 7'h6D, 7'h6D, 7'h7D);
        score = 16'd907;
        wait_done("t3c");
        wait_done("t3d");
        check_display("t3z", 7'h07, 7'h3F, 7'h6F, 7'h00, 7'h00);

        // 4: high score
        pulse_go(16'd500);
        chk("hs_500", 32'(high_score), 32'd500);
        pulse_go(16'd300);
        chk("hs_keep", 32'(high_score), 32'd500);
        pulse_go(16'd501);
        chk("hs_501", 32'(high_score), 32'd501);
        score     = 16'd7;
        show_high = 1'b1;
        wait_done("t4a");
        wait_done("t4b");
        check_display("t4", 7'h06, 7'h3F, 7'h6D, 7'h00, 7'h00);

        // 5: score change mid-SHIFT is held off
        show_high = 1'b0;
        score     = 16'd100;
        wait_done("t5a");
        wait_done("t5b");
        repeat (3) @(negedge clk);
        score = 16'd200;
        wait_done("t5c");
        seen = 0;
        got  = '0;
        for (int k = 0; k < 17; k++) begin
            @(negedge clk);
            if (!seen && digit_sel == 5'b00100) begin
                seen = 1;
                got  = seg;
            end
        end
        chk("t5_seen", 32'(seen), 32'd1);
        chk("t5_hold", 32'(got), 32'h06);
        wait_done("t5d");
        check_display("t5new", 7'h3F, 7'h3F, 7'h5B, 7'h00, 7'h00);

        // 6: async reset mid-SHIFT
        show_high = 1'b1;
        wait_done("t6a");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6_seg", 32'(seg), 32'd0);
        chk("t6_sel", 32'(digit_sel), 32'd0);
        chk("t6_high", 32'(high_score), 32'd0);
        chk("t6_done", 32'(conv_done), 32'd0);
        #1;
        rst_n = 1'b1;
        first_done("t6");
        check_display("t6", 7'h3F, 7'h00, 7'h00, 7'h00, 7'h00);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/dino_score_display.md
Name: dino_score_display

Overview:
- Display-side consumer of the 16-bit dino game score bus; the read end of the score interface.
- Tracks the session high score and converts the selected value (live or high) to 5-digit BCD with a sequential double-dabble converter.
- Time-multiplexes the digits onto one 7-segment bus with leading-zero blanking.
- Sits between the score counter and the board's 7-segment pins.

Parameters:
- SCAN_DIV, 1024: clocks each digit stays enabled. Legal range >= 2. Prescaler width is $clog2(SCAN_DIV).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset; one clock, reset asynchronous, active-low.
- score  input  16  live score from the score counter, unsigned.
- game_over  input  1  game-over pulse, same signal the score counter receives.
- show_high  input  1  1 = display high score, 0 = display live score.
- seg  output  7  segment drive {g,f,e,d,c,b,a}, active-high, registered.
- digit_sel  output  5  one-hot digit enable, bit0 = ones digit, registered.
- conv_done  output  1  one-cycle pulse when a new BCD value is latched.
- high_score  output  16  session maximum score, registered.

Behaviour:
- Reset (async, immediate):
  - seg=0, digit_sel=0, conv_done=0, high_score=0.
  - Display BCD register=0, FSM=IDLE, prescaler=0, digit index=0.
- High score:
  - On any clk edge with game_over=1: if score > high_score (unsigned), high_score <= score.
  - A multi-cycle game_over is harmless.
  - The comparison uses the score value present in that same cycle.
- Converter FSM (IDLE -> SHIFT -> LATCH -> IDLE), free-running with an 18-cycle period:
  - IDLE (1 cycle): capture src = show_high ? high_score : score into a 16-bit shift register. Clear the 20-bit BCD accumulator and the bit counter.
  - SHIFT (16 cycles): each cycle, add 3 to every accumulator nibble >= 5, then shift {acc, bin} left by 1. After 16 shifts go to LATCH.
  - LATCH (1 cycle): copy the accumulator to the display BCD register, set conv_done=1 for this cycle, return to IDLE.
  - Latency: the display register reflects src sampled at IDLE, visible in the cycle after LATCH (17 clocks after capture).
  - Changes to score or show_high mid-conversion do not affect the current conversion; they are taken at the next IDLE.
- Scan:
  - The prescaler counts 0..SCAN_DIV-1. On wrap, the digit index advances 0,1,2,3,4,0.
  - digit_sel and seg are registered from the same index and update in the same cycle. digit_sel = 1 << index.
  - From the first clock after reset release, digit_sel = 5'b00001.
- Segment decode: 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F. Nibbles A-F (unreachable) decode to 00.
- Leading-zero blanking: digit i (i >= 1) shows seg=00 when nibbles i..4 are all zero. Digit 0 is never blanked, so a value of 0 shows a single "0".
- Range: max 65535 fits 5 BCD digits; no overflow path exists.

Decomposition:
- Shared package dino_pkg:
  - SCORE_W=16, NUM_DIGITS=5.
  - Converter state enum {ST_IDLE, ST_SHIFT, ST_LATCH}.
  - SEG7 decode constant table, indexed by nibble.
- Sub-module bin2bcd_seq: the 16-bit-to-20-bit sequential double-dabble converter with start/done, owning the FSM.
- The top level holds the high-score register, source mux, display register, prescaler/scan and decode.

Test Plan:
1. Reset, then release with score=0 and SCAN_DIV=4 -> during reset all outputs 0. First post-reset cycle digit_sel=00001. conv_done pulses at cycle 18. Digit0 seg=3F; digits 1-4 seg=00.
2. score=12345, SCAN_DIV=4, scan a full cycle -> digit0..4 seg = 6D,66,4F,5B,06. conv_done is exactly 1 cycle wide every 18 cycles.
3. score=65535 -> digit0..4 seg = 6D,4F,6D,6D,7D. score=907 -> 07,3F,6F,00,00 (interior zero shown, leading zeros blanked).
4. score=500 with game_over pulse -> high_score=500. Then score=300 with game_over -> high_score stays 500. Then score=501 with game_over -> 501. show_high=1 -> display reads 06,3F,6D,00,00 after the next LATCH.
5. Change score from 100 to 200 during SHIFT -> the following LATCH still shows 100. The next conversion shows 200.
6. Assert rst_n low mid-SHIFT -> seg, digit_sel and high_score clear immediately without a clock edge. After release the conversion restarts from IDLE, and the first conv_done is 18 cycles later.
